// File: rtl/mlp_layer_seq_if.sv
// Handshake, weight-load and result bus of the time-multiplexed dense layer.
// The slave side is the layer itself; the master side drives runs and weight loads.
interface mlp_layer_seq_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 8,
  parameter int XW    = 4,
  parameter int WW    = 4,
  parameter int OW    = 8
);
  localparam int NW  = N_OUT * (N_IN + 1);
  localparam int ADW = (NW > 1) ? $clog2(NW) : 1;
  localparam int KW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                    en_i;
  logic                    w_we_i;
  logic [ADW-1:0]          w_addr_i;
  logic signed [WW-1:0]    w_data_i;
  logic                    start_i;
  logic [N_IN*XW-1:0]      x_i;
  logic                    relu_i;
  logic                    busy_o;
  logic                    y_valid_o;
  logic [KW-1:0]           y_idx_o;
  logic signed [OW-1:0]    y_o;
  logic                    done_o;

  modport slave (
    input  en_i, w_we_i, w_addr_i, w_data_i, start_i, x_i, relu_i,
    output busy_o, y_valid_o, y_idx_o, y_o, done_o
  );
  modport master (
    output en_i, w_we_i, w_addr_i, w_data_i, start_i, x_i, relu_i,
    input  busy_o, y_valid_o, y_idx_o, y_o, done_o
  );
endinterface

// File: rtl/mlp_layer_seq.sv
// Dense layer of N_OUT neurons sharing one MAC: bias load, N_IN MAC cycles per neuron,
// optional ReLU and output saturation, results streamed out with their neuron index.
module mlp_layer_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 8,
  parameter int XW    = 4,
  parameter int WW    = 4,
  parameter int OW    = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  mlp_layer_seq_if.slave bus
);
  localparam int NW  = N_OUT * (N_IN + 1);
  localparam int ADW = (NW > 1) ? $clog2(NW) : 1;
  localparam int KW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int AW  = XW + WW + 1 + $clog2(N_IN + 1);
  localparam int CW  = (AW > OW) ? AW : OW;
  localparam logic signed [CW-1:0] YMAX = CW'((2 ** (OW - 1)) - 1);
  localparam logic signed [CW-1:0] YMIN = CW'(-(2 ** (OW - 1)));

  typedef enum logic [1:0] {IDLE, BIAS, MAC, DONE} state_t;

  state_t                state, state_nx;
  logic [KW-1:0]         k;
  logic [IW-1:0]         i;
  logic signed [AW-1:0]  acc;
  logic [N_IN*XW-1:0]    x_q;
  logic                  relu_q;
  logic signed [WW-1:0]  ram [NW];
  logic                  busy, y_valid, done;
  logic [KW-1:0]         y_idx;
  logic signed [OW-1:0]  y;

  logic [ADW-1:0]        rd_addr;
  logic signed [WW-1:0]  w_rd;
  logic [XW-1:0]         x_cur;
  logic signed [AW-1:0]  prod, sum;
  logic signed [CW-1:0]  r_ext;
  logic signed [OW-1:0]  y_sat;
  logic                  last_i, last_k;

  // Bias sits at slot N_IN of each neuron's weight row.
  always_comb begin
    last_i  = (32'(i) == N_IN - 1);
    last_k  = (32'(k) == N_OUT - 1);
    rd_addr = ADW'(32'(k) * (N_IN + 1) + ((state == BIAS) ? N_IN : 32'(i)));
    w_rd    = ram[rd_addr];
    x_cur   = x_q[32'(i) * XW +: XW];
    prod    = $signed(AW'($signed({1'b0, x_cur}))) * $signed(AW'(w_rd));
    sum     = acc + prod;
    r_ext   = CW'(sum);
    if (relu_q && sum[AW-1]) r_ext = '0;
    if (r_ext > YMAX)      y_sat = OW'(YMAX);
    else if (r_ext < YMIN) y_sat = OW'(YMIN);
    else                   y_sat = OW'(r_ext);
  end

  always_comb begin
    state_nx = state;
    if (bus.en_i) begin
      case (state)
        IDLE:    if (bus.start_i) state_nx = BIAS;
        BIAS:    state_nx = MAC;
        MAC:     if (last_i) state_nx = last_k ? DONE : BIAS;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int a = 0; a < NW; a++) ram[a] <= '0;
      k       <= '0;
      i       <= '0;
      acc     <= '0;
      x_q     <= '0;
      relu_q  <= 1'b0;
      busy    <= 1'b0;
      y_valid <= 1'b0;
      done    <= 1'b0;
      y_idx   <= '0;
      y       <= '0;
    end else begin
      // Pulses drop every edge, stalled or not, so they are never stretched.
      y_valid <= 1'b0;
      done    <= 1'b0;
      if (bus.en_i) begin
        if (bus.w_we_i && !busy && (32'(bus.w_addr_i) < NW))
          ram[bus.w_addr_i] <= bus.w_data_i;
        case (state)
          IDLE: if (bus.start_i) begin
            x_q    <= bus.x_i;
            relu_q <= bus.relu_i;
            busy   <= 1'b1;
            k      <= '0;
          end
          BIAS: begin
            acc <= AW'(w_rd);
            i   <= '0;
          end
          MAC: begin
            acc <= sum;
            i   <= i + 1'b1;
            if (last_i) begin
              y       <= y_sat;
              y_idx   <= k;
              y_valid <= 1'b1;
              if (!last_k) k <= k + 1'b1;
            end
          end
          DONE: begin
            done <= 1'b1;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy_o    = busy;
  assign bus.y_valid_o = y_valid;
  assign bus.y_idx_o   = y_idx;
  assign bus.y_o       = y;
  assign bus.done_o    = done;
endmodule

// File: doc/mlp_layer_seq.md
# mlp_layer_seq

Parametrised, time-multiplexed dense neural layer: N_OUT neurons, each computing a weighted sum of N_IN inputs plus bias, sharing a single multiply-accumulate unit. It supersedes the fixed, fully-parallel hidden/output neuron instances in the chip top. It adds loadable weights, a runtime ReLU mode, output saturation and a start/busy/done handshake. Results stream out one neuron at a time with an index, to feed a following layer or the output pins.

## Interface
- N_IN, 4: inputs per neuron (≥1)
- N_OUT, 8: neurons in layer (≥1)
- XW, 4: input width, unsigned
- WW, 4: weight/bias width, signed two's complement
- OW, 8: output width, signed
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; one clock, reset asynchronous and active-low
- en_i  in  1  clock enable; 0 = stall
- w_we_i  in  1  weight write strobe
- w_addr_i  in  $clog2(N_OUT*(N_IN+1))  weight address; k*(N_IN+1)+i, i=N_IN is bias of neuron k
- w_data_i  in  WW  weight value
- start_i  in  1  start request
- x_i  in  N_IN*XW  input vector, x[i] = x_i[i*XW +: XW], sampled on start
- relu_i  in  1  ReLU enable, sampled on start
- busy_o  out  1  run in progress
- y_valid_o  out  1  one-cycle pulse, y_o/y_idx_o valid
- y_idx_o  out  $clog2(N_OUT) (min 1)  neuron index of y_o
- y_o  out  OW  neuron result
- done_o  out  1  one-cycle pulse, run complete

## Operation
- Accumulator width AW = XW+WW+1+$clog2(N_IN+1), signed. Inputs are zero-extended. Products and bias are sign-extended. No overflow inside AW.
- Weight RAM holds N_OUT*(N_IN+1) entries of WW bits. Reset clears all entries to 0.
- Writes take effect when w_we_i=1, en_i=1 and busy_o=0. Writes while busy or with address ≥ N_OUT*(N_IN+1) are ignored.
- FSM states: IDLE, BIAS, MAC, DONE.
- IDLE: start_i=1 and en_i=1 latches x_i and relu_i, sets busy_o=1, clears k=0 and moves to BIAS. start_i in any other state is ignored.
- BIAS: acc ← bias(k); i=0; go to MAC.
- MAC: acc ← acc + x[i]*w(k,i), i++, for N_IN cycles.
- On the last MAC edge the final sum r is computed and registered:
  - r ← 0 if relu and r<0.
  - r is clamped to [-2^(OW-1), 2^(OW-1)-1] and written to y_o.
  - y_idx_o ← k; y_valid_o pulses.
  - Next state is BIAS with k+1, or DONE if k=N_OUT-1.
- DONE: done_o pulses, busy_o ← 0, go to IDLE.
- en_i=0 holds FSM, counters, acc, latched x and RAM. y_valid_o and done_o clear on that edge; a pulse is never stretched or repeated. y_o and y_idx_o hold.
- Reset (any time, including mid-run) gives IDLE, RAM all 0, busy_o=0, y_valid_o=0, done_o=0, y_o=0, y_idx_o=0. Any partial run is discarded.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- With no stalls, the start-accept edge is edge 0.
- Neuron k result: y_valid_o is high in the cycle after edge (k+1)*(N_IN+1).
- done_o is high and busy_o is low after edge N_OUT*(N_IN+1)+1.
- Defaults: results after edges 5,10,…,40; done after edge 41.
- Back-to-back runs: start_i may be accepted in the cycle done_o is high, since the FSM is in IDLE then. Minimum run period is N_OUT*(N_IN+1)+2 cycles.
- Each cycle of en_i=0 delays every subsequent event by one cycle.

## Test plan
- Reset: hold rst_i=0 → all outputs 0. Release, then start with all-zero RAM → eight y_o=0 with idx 0..7, then done_o after edge 41.
- Basic: every neuron w=1,2,3,4, bias 0; x=1,2,3,4; relu=0 → y_o=30 for idx 0..7 at edges 5..40 (step 5), done_o after edge 41, busy_o high from edge 0 through edge 40.
- ReLU: neuron 0 w=-1×4, bias 0, x=15×4 → relu=0 gives y_o=-60; relu=1 gives y_o=0.
- Saturation: w=7×4, bias 7, x=15 → sum 427, y_o=127. With w=-8×4, bias -8 → sum -488, y_o=-128.
- Stall/ignores: basic setup, en_i=0 for 3 cycles during neuron 2 → done_o after edge 44, no duplicated y_valid_o. start_i pulsed mid-run is ignored. Weight write mid-run is ignored, so the next run still gives 30.
- Reset mid-run: rst_i low during MAC of neuron 3 → busy_o=0 immediately, no further y_valid_o. Next run returns y_o=0 for all neurons because the RAM was cleared.
